// File: rtl/proc_pipe_rv32_top.sv
// proc_pipe_rv32_top
//   In-order, single-issue 5-stage RV32I subset pipeline (IF, ID, EX, MEM, WB)
//   with internal instruction and data word memories. Only sequential fetch.
//
//   Build option: PROC_FWD_EN
//     defined   -> EX/MEM and MEM/WB forwarding into EX; only the 1-cycle
//                  load-use stall remains.
//     undefined -> no forwarding; ID waits while a producer sits in EX or MEM.
//   Architectural results are identical in both builds.
//
//   Ports
//     clk           rising-edge clock
//     resetn        synchronous reset, active HIGH (held in reset while 1)
//     retire_valid  non-bubble instruction in WB this cycle
//     retire_pc     PC of the retiring instruction
//     retire_we     retiring instruction writes rd (rd != x0)
//     retire_rd     destination register
//     retire_wdata  value written to rd
//     fetch_pc      current IF PC
module proc_pipe_rv32_top #(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned DMEM_DEPTH = 256,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic        clk,
   input  logic        resetn,
   output logic        retire_valid,
   output logic [31:0] retire_pc,
   output logic        retire_we,
   output logic [4:0]  retire_rd,
   output logic [31:0] retire_wdata,
   output logic [31:0] fetch_pc
);
   localparam int IW = $clog2(IMEM_DEPTH);
   localparam int DW = $clog2(DMEM_DEPTH);

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   // Instruction memory is loaded externally (not reset); data memory is not reset.
   logic [31:0] imem [IMEM_DEPTH];
   logic [31:0] dmem [DMEM_DEPTH];
   logic [31:0] rf_q [32];

   logic [31:0] pc_q, pc_d;
   logic        stall;

   logic        ifid_valid_q;
   logic [31:0] ifid_pc_q, ifid_instr_q;

   logic        idex_valid_q, idex_is_r_q, idex_is_lw_q, idex_is_sw_q, idex_we_q;
   logic [31:0] idex_pc_q, idex_rs1_val_q, idex_rs2_val_q, idex_imm_q;
   logic [4:0]  idex_rd_q, idex_rs1_q, idex_rs2_q;
   alu_op_e     idex_alu_q;

   logic        exmem_valid_q, exmem_we_q, exmem_is_lw_q, exmem_is_sw_q;
   logic [31:0] exmem_pc_q, exmem_res_q, exmem_sdata_q;
   logic [4:0]  exmem_rd_q;

   logic        memwb_valid_q, memwb_we_q;
   logic [31:0] memwb_pc_q, memwb_wdata_q;
   logic [4:0]  memwb_rd_q;

   // ---------------- ID: decode, register read, hazard detection
   logic [6:0]  id_opcode, id_f7;
   logic [2:0]  id_f3;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_is_r, id_is_i, id_is_lw, id_is_sw, id_use_rs1, id_use_rs2, id_we;
   logic [31:0] id_imm, id_rs1_val, id_rs2_val;
   alu_op_e     id_alu;

   always_comb begin
      id_opcode  = ifid_instr_q[6:0];
      id_rd      = ifid_instr_q[11:7];
      id_f3      = ifid_instr_q[14:12];
      id_rs1     = ifid_instr_q[19:15];
      id_rs2     = ifid_instr_q[24:20];
      id_f7      = ifid_instr_q[31:25];
      id_is_r    = (id_opcode == 7'b0110011) &&
                   ((id_f7 == 7'h00) || ((id_f7 == 7'h20) && ((id_f3 == 3'b000) || (id_f3 == 3'b101))));
      // Immediate shifts are not part of the subset and fall through as NOPs.
      id_is_i    = (id_opcode == 7'b0010011) && (id_f3 != 3'b001) && (id_f3 != 3'b101);
      id_is_lw   = (id_opcode == 7'b0000011) && (id_f3 == 3'b010);
      id_is_sw   = (id_opcode == 7'b0100011) && (id_f3 == 3'b010);
      id_use_rs1 = id_is_r || id_is_i || id_is_lw || id_is_sw;
      id_use_rs2 = id_is_r || id_is_sw;
      id_we      = (id_is_r || id_is_i || id_is_lw) && (id_rd != 5'd0);
      id_imm     = id_is_sw ? {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]}
                            : {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
      id_alu     = ALU_ADD;
      if (id_is_r || id_is_i) begin
         case (id_f3)
            3'b000:  id_alu = (id_is_r && id_f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  id_alu = ALU_SLL;
            3'b010:  id_alu = ALU_SLT;
            3'b011:  id_alu = ALU_SLTU;
            3'b100:  id_alu = ALU_XOR;
            3'b101:  id_alu = id_f7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  id_alu = ALU_OR;
            default: id_alu = ALU_AND;
         endcase
      end
   end

   // Write-before-read: the value retiring this cycle is visible to ID.
   always_comb begin
      id_rs1_val = 32'd0;
      id_rs2_val = 32'd0;
      if (id_rs1 != 5'd0)
         id_rs1_val = (memwb_we_q && (memwb_rd_q == id_rs1)) ? memwb_wdata_q : rf_q[id_rs1];
      if (id_rs2 != 5'd0)
         id_rs2_val = (memwb_we_q && (memwb_rd_q == id_rs2)) ? memwb_wdata_q : rf_q[id_rs2];
   end

   // *_we_q already excludes rd == x0, so a match never fires on x0 sources.
   logic id_hit_ex;
   assign id_hit_ex = idex_valid_q && idex_we_q &&
                      ((id_use_rs1 && (id_rs1 == idex_rd_q)) || (id_use_rs2 && (id_rs2 == idex_rd_q)));

`ifdef PROC_FWD_EN
   assign stall = ifid_valid_q && id_hit_ex && idex_is_lw_q;
`else
   logic id_hit_mem;
   assign id_hit_mem = exmem_valid_q && exmem_we_q &&
                       ((id_use_rs1 && (id_rs1 == exmem_rd_q)) || (id_use_rs2 && (id_rs2 == exmem_rd_q)));
   assign stall = ifid_valid_q && (id_hit_ex || id_hit_mem);
`endif

   assign pc_d = stall ? pc_q : pc_q + 32'd4;

   // ---------------- EX
   logic [31:0] ex_a, ex_rs2, ex_b, ex_res;

   always_comb begin
      ex_a   = idex_rs1_val_q;
      ex_rs2 = idex_rs2_val_q;
`ifdef PROC_FWD_EN
      // MEM/WB applied first, then EX/MEM overrides it: youngest producer wins.
      if (memwb_we_q && (memwb_rd_q == idex_rs1_q)) ex_a   = memwb_wdata_q;
      if (memwb_we_q && (memwb_rd_q == idex_rs2_q)) ex_rs2 = memwb_wdata_q;
      // A load in MEM never needs forwarding here: the load-use stall keeps
      // its consumer back until the load has reached WB.
      if (exmem_valid_q && exmem_we_q && !exmem_is_lw_q && (exmem_rd_q == idex_rs1_q)) ex_a   = exmem_res_q;
      if (exmem_valid_q && exmem_we_q && !exmem_is_lw_q && (exmem_rd_q == idex_rs2_q)) ex_rs2 = exmem_res_q;
`endif
      ex_b = idex_is_r_q ? ex_rs2 : idex_imm_q;
      case (idex_alu_q)
         ALU_ADD:  ex_res = ex_a + ex_b;
         ALU_SUB:  ex_res = ex_a - ex_b;
         ALU_SLL:  ex_res = ex_a << ex_b[4:0];
         ALU_SLT:  ex_res = {31'd0, $signed(ex_a) < $signed(ex_b)};
         ALU_SLTU: ex_res = {31'd0, ex_a < ex_b};
         ALU_XOR:  ex_res = ex_a ^ ex_b;
         ALU_SRL:  ex_res = ex_a >> ex_b[4:0];
         ALU_SRA:  ex_res = $unsigned($signed(ex_a) >>> ex_b[4:0]);
         ALU_OR:   ex_res = ex_a | ex_b;
         ALU_AND:  ex_res = ex_a & ex_b;
         default:  ex_res = ex_a + ex_b;
      endcase
   end

   // ---------------- MEM
   logic [DW-1:0] mem_idx;
   logic [31:0]   mem_wdata;

   assign mem_idx   = exmem_res_q[DW+1:2];
   assign mem_wdata = exmem_is_lw_q ? dmem[mem_idx] : exmem_res_q;

   always_ff @(posedge clk) begin
      if (!resetn && exmem_valid_q && exmem_is_sw_q)
         dmem[mem_idx] <= exmem_sdata_q;
   end

   // ---------------- pipeline registers and register file
   always_ff @(posedge clk) begin
      if (resetn) begin
         pc_q          <= RESET_PC;
         ifid_valid_q  <= 1'b0;
         idex_valid_q  <= 1'b0;
         exmem_valid_q <= 1'b0;
         memwb_valid_q <= 1'b0;
         memwb_we_q    <= 1'b0;
         memwb_pc_q    <= 32'd0;
         memwb_rd_q    <= 5'd0;
         memwb_wdata_q <= 32'd0;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else begin
         pc_q <= pc_d;
         if (!stall) begin
            ifid_valid_q <= 1'b1;
            ifid_pc_q    <= pc_q;
            ifid_instr_q <= imem[pc_q[IW+1:2]];
         end

         idex_valid_q   <= ifid_valid_q && !stall;
         idex_pc_q      <= ifid_pc_q;
         idex_is_r_q    <= id_is_r;
         idex_is_lw_q   <= id_is_lw;
         idex_is_sw_q   <= id_is_sw;
         idex_we_q      <= id_we;
         idex_rd_q      <= id_rd;
         idex_rs1_q     <= id_rs1;
         idex_rs2_q     <= id_rs2;
         idex_rs1_val_q <= id_rs1_val;
         idex_rs2_val_q <= id_rs2_val;
         idex_imm_q     <= id_imm;
         idex_alu_q     <= id_alu;

         exmem_valid_q <= idex_valid_q;
         exmem_pc_q    <= idex_pc_q;
         exmem_we_q    <= idex_we_q;
         exmem_is_lw_q <= idex_is_lw_q;
         exmem_is_sw_q <= idex_is_sw_q;
         exmem_rd_q    <= idex_rd_q;
         exmem_res_q   <= ex_res;
         exmem_sdata_q <= ex_rs2;

         memwb_valid_q <= exmem_valid_q;
         memwb_we_q    <= exmem_valid_q && exmem_we_q;
         memwb_pc_q    <= exmem_pc_q;
         memwb_rd_q    <= exmem_rd_q;
         memwb_wdata_q <= mem_wdata;

         if (memwb_we_q) rf_q[memwb_rd_q] <= memwb_wdata_q;
      end
   end

   assign retire_valid = memwb_valid_q;
   assign retire_pc    = memwb_pc_q;
   assign retire_we    = memwb_we_q;
   assign retire_rd    = memwb_rd_q;
   assign retire_wdata = memwb_wdata_q;
   assign fetch_pc     = pc_q;

`ifdef PROC_FWD_EN
   logic unused_bits;
   assign unused_bits = ^{pc_q[1:0], pc_q[31:IW+2], exmem_pc_q[0]};
`else
   logic unused_bits;
   assign unused_bits = ^{pc_q[1:0], pc_q[31:IW+2], exmem_pc_q[0], idex_rs1_q, idex_rs2_q};
`endif

endmodule

// File: tb/tb_proc_pipe_rv32_top.sv
module tb_proc_pipe_rv32_top;
   logic        clk = 1'b0;
   logic        resetn = 1'b1;
   logic        retire_valid, retire_we;
   logic [31:0] retire_pc, retire_wdata, fetch_pc;
   logic [4:0]  retire_rd;

   proc_pipe_rv32_top dut (
      .clk(clk), .resetn(resetn),
      .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_we(retire_we),
      .retire_rd(retire_rd), .retire_wdata(retire_wdata), .fetch_pc(fetch_pc)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic        we;
      logic [4:0]  rd;
      logic [31:0] wdata;
      logic [31:0] cyc;
   } ret_t;

   int n_checks = 0;
   int n_pass   = 0;
   ret_t obs_q[$];
   ret_t exp_q[$];

   // ISA-level reference state
   logic [31:0] m_regs [32];
   logic [31:0] m_dmem [256];
   int          wr_words[$];

   // directed program and its architecturally required retires
   logic [31:0] prog_d [13];
   logic        d_we [13] = '{1,1,1,1,1,1,0,1,1,1,0,0,1};
   logic [4:0]  d_rd [13] = '{1,2,1,2,1,1,0,2,3,4,0,0,5};
   logic [31:0] d_wd [13] = '{25,75,100,25,75,72,0,25,25,50,0,0,7};

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
      return {imm, rs1, f3, rd, 7'h13};
   endfunction
   function automatic logic [31:0] enc_lw(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
      return {imm, rs1, 3'b010, rd, 7'h03};
   endfunction
   function automatic logic [31:0] enc_sw(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
      return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
   endfunction

   // Executes one instruction architecturally and returns what must retire.
   task automatic model_exec(input logic [31:0] ins, input logic [31:0] pc, output ret_t r);
      logic [31:0] a, b, imm, v, addr;
      logic [2:0]  f3;
      logic [6:0]  f7;
      logic        wr;
      f3  = ins[14:12];
      f7  = ins[31:25];
      a   = (ins[19:15] == 0) ? 32'd0 : m_regs[ins[19:15]];
      b   = (ins[24:20] == 0) ? 32'd0 : m_regs[ins[24:20]];
      imm = {{20{ins[31]}}, ins[31:20]};
      wr  = 1'b0;
      v   = 32'd0;
      if (ins[6:0] == 7'h33 && (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) begin
         wr = 1'b1;
         case (f3)
            3'd0: v = (f7 == 7'h20) ? a - b : a + b;
            3'd1: v = a << b[4:0];
            3'd2: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: v = (a < b) ? 32'd1 : 32'd0;
            3'd4: v = a ^ b;
            3'd5: v = (f7 == 7'h20) ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6: v = a | b;
            default: v = a & b;
         endcase
      end else if (ins[6:0] == 7'h13 && f3 != 3'd1 && f3 != 3'd5) begin
         wr = 1'b1;
         case (f3)
            3'd0: v = a + imm;
            3'd2: v = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
            3'd3: v = (a < imm) ? 32'd1 : 32'd0;
            3'd4: v = a ^ imm;
            3'd6: v = a | imm;
            default: v = a & imm;
         endcase
      end else if (ins[6:0] == 7'h03 && f3 == 3'd2) begin
         wr   = 1'b1;
         addr = a + imm;
         v    = m_dmem[addr[9:2]];
      end else if (ins[6:0] == 7'h23 && f3 == 3'd2) begin
         addr = a + {{20{ins[31]}}, ins[31:25], ins[11:7]};
         m_dmem[addr[9:2]] = b;
      end
      r.pc    = pc;
      r.rd    = ins[11:7];
      r.we    = wr && (ins[11:7] != 0);
      r.wdata = r.we ? v : 32'd0;
      r.cyc   = 32'd0;
      if (r.we) m_regs[ins[11:7]] = v;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      resetn = 1'b0;
   endtask

   // Records retires (cycle numbers relative to reset release); no checking here.
   task automatic collect(input int n, input int budget, output bit timed_out);
      int cyc;
      ret_t r;
      obs_q.delete();
      cyc = 0;
      while (obs_q.size() < n && cyc < budget) begin
         @(negedge clk);
         cyc++;
         if (retire_valid) begin
            r.pc = retire_pc; r.we = retire_we; r.rd = retire_rd; r.wdata = retire_wdata; r.cyc = 32'(cyc);
            obs_q.push_back(r);
         end
      end
      timed_out = (obs_q.size() < n);
   endtask

   task automatic load_directed();
      prog_d[0]  = enc_i(12'd25, 5'd1, 3'd0, 5'd1);
      prog_d[1]  = enc_i(12'd75, 5'd2, 3'd0, 5'd2);
      prog_d[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1);
      prog_d[3]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd2);
      prog_d[4]  = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd1);
      prog_d[5]  = enc_i(12'hFFD, 5'd1, 3'd0, 5'd1);
      prog_d[6]  = 32'h0020a023;
      prog_d[7]  = 32'h0000a103;
      prog_d[8]  = enc_lw(12'd0, 5'd1, 5'd3);
      prog_d[9]  = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4);
      prog_d[10] = enc_i(12'd5, 5'd0, 3'd0, 5'd0);
      prog_d[11] = 32'hFFFFFFFF;
      prog_d[12] = enc_i(12'd7, 5'd0, 3'd0, 5'd5);
      for (int i = 0; i < 256; i++) dut.imem[i] = (i < 13) ? prog_d[i] : 32'hFFFFFFFF;
   endtask

   task automatic test_reset();
      load_directed();
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++; if (fetch_pc !== 32'd0) $display("FAIL reset_fetch_pc got=%h exp=0", fetch_pc); else n_pass++;
      n_checks++; if (retire_valid !== 1'b0 || retire_we !== 1'b0 || retire_pc !== 32'd0 ||
                      retire_rd !== 5'd0 || retire_wdata !== 32'd0)
         $display("FAIL reset_retire_outputs got v=%b we=%b pc=%h rd=%0d wd=%h exp all 0",
                  retire_valid, retire_we, retire_pc, retire_rd, retire_wdata);
      else n_pass++;
      resetn = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k < 4) begin
            n_checks++; if (retire_valid !== 1'b0) $display("FAIL reset_no_early_retire cycle=%0d got=%b exp=0", k, retire_valid); else n_pass++;
            n_checks++; if (fetch_pc !== 32'(4 * k)) $display("FAIL reset_fetch_seq cycle=%0d got=%h exp=%h", k, fetch_pc, 4 * k); else n_pass++;
         end else begin
            n_checks++; if (retire_valid !== 1'b1 || retire_pc !== 32'd0 || retire_we !== 1'b1 ||
                            retire_rd !== 5'd1 || retire_wdata !== 32'd25)
               $display("FAIL reset_first_retire got v=%b pc=%h we=%b rd=%0d wd=%0d exp v=1 pc=0 we=1 rd=1 wd=25",
                        retire_valid, retire_pc, retire_we, retire_rd, retire_wdata);
            else n_pass++;
         end
      end
   endtask

   task automatic test_directed_program(input string tag);
      bit to;
      collect(13, 120, to);
      n_checks++; if (to) $display("FAIL %s_timeout got=%0d retires exp=13", tag, obs_q.size()); else n_pass++;
      for (int i = 0; i < obs_q.size(); i++) begin
         n_checks++;
         if (obs_q[i].pc !== 32'(4 * i) || obs_q[i].we !== d_we[i] ||
             (d_we[i] && (obs_q[i].rd !== d_rd[i] || obs_q[i].wdata !== d_wd[i])))
            $display("FAIL %s_retire%0d got pc=%h we=%b rd=%0d wd=%0d exp pc=%h we=%b rd=%0d wd=%0d", tag, i,
                     obs_q[i].pc, obs_q[i].we, obs_q[i].rd, obs_q[i].wdata, 4 * i, d_we[i], d_rd[i], d_wd[i]);
         else n_pass++;
      end
      if (obs_q.size() == 13) begin
         n_checks++; if (obs_q[0].cyc !== 32'd4) $display("FAIL %s_first_latency got=%0d exp=4", tag, obs_q[0].cyc); else n_pass++;
`ifdef PROC_FWD_EN
         for (int i = 1; i < 6; i++) begin
            n_checks++;
            if (obs_q[i].cyc - obs_q[i-1].cyc !== 32'd1)
               $display("FAIL %s_chain_gap%0d got=%0d exp=1", tag, i, obs_q[i].cyc - obs_q[i-1].cyc);
            else n_pass++;
         end
         n_checks++; if (obs_q[9].cyc - obs_q[8].cyc !== 32'd2)
            $display("FAIL %s_load_use_gap got=%0d exp=2", tag, obs_q[9].cyc - obs_q[8].cyc); else n_pass++;
`else
         n_checks++; if (obs_q[9].cyc - obs_q[8].cyc !== 32'd3)
            $display("FAIL %s_load_use_gap got=%0d exp=3", tag, obs_q[9].cyc - obs_q[8].cyc); else n_pass++;
`endif
      end
      n_checks++; if (dut.dmem[18] !== 32'd25) $display("FAIL %s_dmem72 got=%0d exp=25", tag, dut.dmem[18]); else n_pass++;
   endtask

   task automatic test_alu_chain();
      load_directed();
      apply_reset();
      test_directed_program("chain");
   endtask

   task automatic test_mid_reset();
      bit to;
      load_directed();
      apply_reset();
      collect(3, 40, to);
      n_checks++; if (to) $display("FAIL midreset_pre_timeout got=%0d exp=3", obs_q.size()); else n_pass++;
      resetn = 1'b1;
      @(negedge clk);
      n_checks++; if (retire_valid !== 1'b0) $display("FAIL midreset_squash got=%b exp=0", retire_valid); else n_pass++;
      n_checks++; if (dut.rf_q[1] !== 32'd0 || dut.rf_q[2] !== 32'd0)
         $display("FAIL midreset_regs got x1=%0d x2=%0d exp 0 0", dut.rf_q[1], dut.rf_q[2]); else n_pass++;
      n_checks++; if (fetch_pc !== 32'd0) $display("FAIL midreset_fetch_pc got=%h exp=0", fetch_pc); else n_pass++;
      resetn = 1'b0;
      test_directed_program("restart");
   endtask

   task automatic test_random(input int n_prog, input int len);
      ret_t        r;
      logic [31:0] ins, addr;
      logic [4:0]  rd, rs1, rs2;
      logic [2:0]  f3;
      logic [11:0] imm;
      int          sel, w, off;
      bit          to;
      for (int p = 0; p < n_prog; p++) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
         wr_words.delete();
         exp_q.delete();
         for (int i = 0; i < len; i++) begin
            sel = $urandom_range(0, 9);
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            f3  = 3'($urandom_range(0, 7));
            imm = 12'($urandom);
            if (sel == 7 || sel == 8) begin
               if (wr_words.size() == 0) sel = 6;
            end
            case (sel)
               0, 1, 2, 3: ins = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                       rs2, rs1, f3, rd);
               4, 5: begin
                  if (f3 == 3'd1 || f3 == 3'd5) f3 = 3'd0;
                  ins = enc_i(imm, rs1, f3, rd);
               end
               6: begin
                  ins  = enc_sw(imm, rs2, rs1);
                  addr = ((rs1 == 0) ? 32'd0 : m_regs[rs1]) + {{20{imm[11]}}, imm};
                  wr_words.push_back(int'(addr[9:2]));
               end
               7, 8: begin
                  w   = wr_words[$urandom_range(0, wr_words.size() - 1)];
                  off = $urandom_range(0, 2);
                  ins = enc_lw(12'(w * 4 + $urandom_range(0, 3) + ((off == 1) ? 1024 : (off == 2) ? -1024 : 0)),
                               5'd0, rd);
               end
               default: ins = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : enc_i(imm, rs1, 3'd1, rd);
            endcase
            dut.imem[i] = ins;
            model_exec(ins, 32'(4 * i), r);
            exp_q.push_back(r);
         end
         for (int i = len; i < 256; i++) dut.imem[i] = 32'hFFFFFFFF;
         apply_reset();
         collect(len, len * 4 + 20, to);
         n_checks++; if (to) $display("FAIL random%0d_timeout got=%0d exp=%0d", p, obs_q.size(), len); else n_pass++;
         for (int i = 0; i < obs_q.size(); i++) begin
            n_checks++;
            if (obs_q[i].pc !== exp_q[i].pc || obs_q[i].we !== exp_q[i].we ||
                (exp_q[i].we && (obs_q[i].rd !== exp_q[i].rd || obs_q[i].wdata !== exp_q[i].wdata)))
               $display("FAIL random%0d_retire%0d got pc=%h we=%b rd=%0d wd=%h exp pc=%h we=%b rd=%0d wd=%h", p, i,
                        obs_q[i].pc, obs_q[i].we, obs_q[i].rd, obs_q[i].wdata,
                        exp_q[i].pc, exp_q[i].we, exp_q[i].rd, exp_q[i].wdata);
            else n_pass++;
         end
      end
   endtask

   task automatic test_fetch_wrap();
      bit to;
      for (int i = 0; i < 256; i++) dut.imem[i] = enc_i(12'd1, 5'd1, 3'd0, 5'd1);
      apply_reset();
      collect(260, 260 * 4 + 20, to);
      n_checks++; if (to) $display("FAIL wrap_timeout got=%0d exp=260", obs_q.size()); else n_pass++;
      for (int k = 0; k < obs_q.size(); k++) begin
         n_checks++;
         if (obs_q[k].pc !== 32'(4 * k) || obs_q[k].wdata !== 32'(k + 1))
            $display("FAIL wrap_retire%0d got pc=%h wd=%0d exp pc=%h wd=%0d", k, obs_q[k].pc, obs_q[k].wdata, 4 * k, k + 1);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_alu_chain();
      test_mid_reset();
      test_random(4, 120);
      test_fetch_wrap();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
